// File: rtl/s_port_byte_out.sv
// s_port_byte_out: serial byte transmitter fed by a small write FIFO.
// Define S_PORT_TX_ODD_PARITY_EN for odd parity; default is even parity.
module s_port_byte_out #(
   parameter logic [14:0] PERIOD_VALUE = 15'h43d1,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_AW      = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         byte_in,
   input  logic               byte_in_en,
   output logic               fifo_full,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   output logic               tx_busy,
   output logic               s_out
);

   localparam int unsigned      DEPTH     = 2**FIFO_AW;
   localparam logic [FIFO_AW:0] LVL_FULL  = (FIFO_AW+1)'(DEPTH);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS-1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;
   logic [14:0]        r_cnt;
   logic [14:0]        w_cnt_nx;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_nx;
   logic [2:0]         r_bit;
   logic [2:0]         w_bit_nx;
   logic               r_par;
   logic               w_par_nx;
   logic               r_sout;
   logic               w_sout_nx;
   logic               w_pop;

   logic [7:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wptr;
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW:0]   r_level;
   logic               r_full;
   logic               r_ovf;

   logic               w_wr;
   logic               w_has;
   logic               w_wrap;
   logic [7:0]         w_head;
   logic               w_head_par;

   assign w_wr   = byte_in_en && (r_level != LVL_FULL);
   assign w_has  = (r_level != '0);
   assign w_wrap = (r_cnt == PERIOD_VALUE);
   assign w_head = r_mem[r_rptr];

`ifdef S_PORT_TX_ODD_PARITY_EN
   assign w_head_par = ~^w_head;
`else
   assign w_head_par = ^w_head;
`endif

   // Storage needs no reset; pointers and level define validity.
   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wptr] <= byte_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_ovf <= byte_in_en && (r_level == LVL_FULL);
         if (w_wr)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10: begin
               r_level <= r_level + 1'b1;
               r_full  <= (r_level + 1'b1) == LVL_FULL;
            end
            2'b01: begin
               r_level <= r_level - 1'b1;
               r_full  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_bit   <= '0;
         r_par   <= 1'b0;
         r_sout  <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_shift <= w_shift_nx;
         r_bit   <= w_bit_nx;
         r_par   <= w_par_nx;
         r_sout  <= w_sout_nx;
      end
   end

   // r_bit indexes data bits in DATA and stop bits in STOP.
   always_comb begin
      w_state_nx = r_state;
      w_shift_nx = r_shift;
      w_bit_nx   = r_bit;
      w_par_nx   = r_par;
      w_sout_nx  = r_sout;
      w_pop      = 1'b0;
      w_cnt_nx   = (r_state == IDLE || w_wrap) ? '0 : r_cnt + 15'd1;

      unique case (r_state)
         IDLE: begin
            w_sout_nx = 1'b1;
            w_pop     = w_has;
         end
         START: begin
            if (w_wrap) begin
               w_state_nx = DATA;
               w_sout_nx  = r_shift[0];
               w_bit_nx   = '0;
            end
         end
         DATA: begin
            if (w_wrap) begin
               if (r_bit == 3'd7) begin
                  w_state_nx = PARITY;
                  w_sout_nx  = r_par;
               end else begin
                  w_shift_nx = r_shift >> 1;
                  w_sout_nx  = r_shift[1];
                  w_bit_nx   = r_bit + 3'd1;
               end
            end
         end
         PARITY: begin
            if (w_wrap) begin
               w_state_nx = STOP;
               w_sout_nx  = 1'b1;
               w_bit_nx   = '0;
            end
         end
         STOP: begin
            if (w_wrap) begin
               if (r_bit == STOP_LAST) begin
                  w_state_nx = IDLE;
                  w_pop      = w_has;
               end else begin
                  w_bit_nx = r_bit + 3'd1;
               end
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_sout_nx  = 1'b1;
         end
      endcase

      if (w_pop) begin
         w_state_nx = START;
         w_shift_nx = w_head;
         w_par_nx   = w_head_par;
         w_sout_nx  = 1'b0;
         w_bit_nx   = '0;
      end
   end

   assign s_out      = r_sout;
   assign tx_busy    = (r_state != IDLE);
   assign fifo_level = r_level;
   assign fifo_full  = r_full;
   assign overflow   = r_ovf;

endmodule
